// File: rtl/row_clear_ctrl_pkg.sv
// Shared board geometry, state encoding and helpers for the row-clear sequencer.
package row_clear_ctrl_pkg;

  localparam int BOARD_WIDTH_BLK  = 10;
  localparam int BOARD_HEIGHT_BLK = 20;
  localparam int LINES_W          = 3;

  localparam logic [LINES_W-1:0] LINES_MAX = '1;

  typedef enum logic [2:0] {
    RC_IDLE,
    RC_SCAN,
    RC_SHIFT,
    RC_FLASH,
    RC_DONE
  } rc_state_e;

  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v);
    return (v == LINES_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/row_clear_ctrl_full_detect.sv
// Combinational "row is full" test: ANDs the BOARD_W bits of the selected row.
module row_full_detect
  import row_clear_ctrl_pkg::*;
#(
  parameter int BOARD_W = BOARD_WIDTH_BLK,
  parameter int BOARD_H = BOARD_HEIGHT_BLK,
  parameter int ROW_W   = (BOARD_H > 1) ? $clog2(BOARD_H) : 1
) (
  input  logic [BOARD_W*BOARD_H-1:0] board_i,
  input  logic [ROW_W-1:0]           row_i,
  output logic                       full_o
);

  logic [BOARD_W-1:0] rowBits;

  always_comb begin
    rowBits = '0;
    for (int r = 0; r < BOARD_H; r++) begin
      if (row_i == ROW_W'(r)) rowBits = board_i[r*BOARD_W +: BOARD_W];
    end
  end

  assign full_o = &rowBits;

endmodule

// File: rtl/row_clear_ctrl.sv
// Row-clear sequencer: scans bottom-to-top, shifts full rows out one per pass.
// Optional flash hold before each shift is enabled by ROW_CLEAR_FLASH_EN.
module row_clear_ctrl
  import row_clear_ctrl_pkg::*;
#(
  parameter int BOARD_W      = BOARD_WIDTH_BLK,
  parameter int BOARD_H      = BOARD_HEIGHT_BLK,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BOARD_W*BOARD_H-1:0] board_in,
  output logic [BOARD_W*BOARD_H-1:0] board_out,
  output logic                       busy,
  output logic                       done,
  output logic                       score_pulse,
  output logic [LINES_W-1:0]         lines_cleared,
  output logic [BOARD_H-1:0]         flash_mask
);

  localparam int ROW_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam int N     = BOARD_W * BOARD_H;

  rc_state_e          state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [N-1:0]       work_q, work_d;
  logic [LINES_W-1:0] count_q, count_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;
  logic               rowFull;
  logic [N-1:0]       shifted;

`ifdef ROW_CLEAR_FLASH_EN
  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  logic [FLASH_W-1:0] flashCnt_q, flashCnt_d;
  logic [BOARD_H-1:0] flashMask_q, flashMask_d;
`else
  logic unused_flash;
  assign unused_flash = (FLASH_CYCLES != 0);
`endif

  row_full_detect #(
    .BOARD_W(BOARD_W),
    .BOARD_H(BOARD_H),
    .ROW_W  (ROW_W)
  ) u_full (
    .board_i(work_q),
    .row_i  (row_q),
    .full_o (rowFull)
  );

  // Rows 1..row_q drop by one; row 0 always becomes empty.
  always_comb begin
    shifted = work_q;
    shifted[0 +: BOARD_W] = '0;
    for (int r = 1; r < BOARD_H; r++) begin
      if (ROW_W'(r) <= row_q) shifted[r*BOARD_W +: BOARD_W] = work_q[(r-1)*BOARD_W +: BOARD_W];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    work_d  = work_q;
    count_d = count_q;
`ifdef ROW_CLEAR_FLASH_EN
    flashCnt_d = flashCnt_q;
`endif
    unique case (state_q)
      RC_IDLE: begin
        if (start) begin
          work_d  = board_in;
          row_d   = ROW_W'(BOARD_H - 1);
          count_d = '0;
          state_d = RC_SCAN;
        end
      end
      RC_SCAN: begin
        if (rowFull) begin
`ifdef ROW_CLEAR_FLASH_EN
          flashCnt_d = '0;
          state_d    = RC_FLASH;
`else
          state_d    = RC_SHIFT;
`endif
        end else if (row_q != '0) begin
          row_d = row_q - 1'b1;
        end else begin
          state_d = RC_DONE;
        end
      end
      RC_SHIFT: begin
        work_d  = shifted;
        count_d = sat_inc(count_q);
        state_d = RC_SCAN;
      end
`ifdef ROW_CLEAR_FLASH_EN
      RC_FLASH: begin
        if (flashCnt_q == FLASH_W'(FLASH_CYCLES - 1)) state_d = RC_SHIFT;
        else flashCnt_d = flashCnt_q + 1'b1;
      end
`endif
      RC_DONE: state_d = RC_IDLE;
      default: state_d = RC_IDLE;
    endcase

    // Abort freezes the working data where it is and returns to idle.
    if (abort) begin
      state_d = RC_IDLE;
      row_d   = row_q;
      work_d  = work_q;
      count_d = count_q;
    end
  end

  always_comb begin
    done_d  = (state_q == RC_DONE) && !abort;
    pulse_d = (state_q == RC_SHIFT) && !abort;
    lines_d = ((state_q == RC_DONE) && !abort) ? count_q : lines_q;
`ifdef ROW_CLEAR_FLASH_EN
    flashMask_d = ((state_q == RC_FLASH) && !abort) ? (BOARD_H'(1) << row_q) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RC_IDLE;
      row_q   <= '0;
      work_q  <= '0;
      count_q <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
`ifdef ROW_CLEAR_FLASH_EN
      flashCnt_q  <= '0;
      flashMask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      work_q  <= work_d;
      count_q <= count_d;
      lines_q <= lines_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
`ifdef ROW_CLEAR_FLASH_EN
      flashCnt_q  <= flashCnt_d;
      flashMask_q <= flashMask_d;
`endif
    end
  end

  assign board_out     = work_q;
  assign busy          = (state_q == RC_SCAN) || (state_q == RC_SHIFT) || (state_q == RC_FLASH);
  assign done          = done_q;
  assign score_pulse   = pulse_q;
  assign lines_cleared = lines_q;
`ifdef ROW_CLEAR_FLASH_EN
  assign flash_mask    = flashMask_q;
`else
  assign flash_mask    = '0;
`endif

endmodule
